// File: rtl/keccak_round_ctrl_if.sv
// keccak_round_ctrl_if
//   Bundles the request/completion handshake and the datapath strobes of the
//   Keccak-f[1600] round sequencer.
//   master : requester / datapath side (drives start, ack, abort)
//   slave  : the sequencer itself (drives ready, strobes, counters, done)
//   Signals:
//     start, ack, abort         request, completion acknowledge, synchronous abort
//     ready, busy, done         exactly one is high in every cycle
//     load_en, stage_en, commit datapath strobes
//     stage[1:0], iteration[4:0], last_round  position within the permutation
interface keccak_round_ctrl_if;
    logic       start;
    logic       ack;
    logic       abort;
    logic       ready;
    logic       load_en;
    logic       stage_en;
    logic [1:0] stage;
    logic [4:0] iteration;
    logic       commit;
    logic       last_round;
    logic       busy;
    logic       done;

    modport master (
        output start, ack, abort,
        input  ready, load_en, stage_en, stage, iteration, commit, last_round, busy, done
    );

    modport slave (
        input  start, ack, abort,
        output ready, load_en, stage_en, stage, iteration, commit, last_round, busy, done
    );
endinterface

// File: rtl/keccak_round_ctrl.sv
// keccak_round_ctrl
//   Round sequencer for the Keccak-f[1600] permutation core. After a start/ready
//   request it strobes load_en for one cycle, then runs NUM_ROUNDS rounds of
//   STAGES cycles each, presenting the round index to the round-constant table and
//   pulsing commit on the final stage of every round. The result is signalled with
//   done, held until ack.
//   Parameters:
//     NUM_ROUNDS  rounds per permutation, 1..24
//     STAGES      cycles per round, 1..4
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     ctrl  handshake / strobe bundle (slave side)
//   Every output is a flop; the next values are computed from the registered state,
//   so there is no combinational path from any input to any output.
module keccak_round_ctrl #(
    parameter int NUM_ROUNDS = 24,
    parameter int STAGES     = 1
) (
    input  logic                clk,
    input  logic                rst,
    keccak_round_ctrl_if.slave  ctrl
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] LAST_STAGE = 2'(STAGES - 1);
    localparam logic [4:0] LAST_ITER  = 5'(NUM_ROUNDS - 1);
    // Values of commit/last_round for the very first RUN cycle.
    localparam logic FIRST_COMMIT = (STAGES == 1);
    localparam logic FIRST_LAST   = (NUM_ROUNDS == 1);

    state_t     state_q;
    logic [1:0] stage_q;
    logic [4:0] iter_q;
    logic       ready_q;
    logic       load_en_q;
    logic       stage_en_q;
    logic       commit_q;
    logic       last_round_q;
    logic       busy_q;
    logic       done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            stage_q      <= 2'd0;
            iter_q       <= 5'd0;
            ready_q      <= 1'b1;
            load_en_q    <= 1'b0;
            stage_en_q   <= 1'b0;
            commit_q     <= 1'b0;
            last_round_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else if (ctrl.abort) begin
            // Abort outranks start, ack and round advance.
            state_q      <= S_IDLE;
            stage_q      <= 2'd0;
            iter_q       <= 5'd0;
            ready_q      <= 1'b1;
            load_en_q    <= 1'b0;
            stage_en_q   <= 1'b0;
            commit_q     <= 1'b0;
            last_round_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ctrl.start) begin
                        state_q   <= S_LOAD;
                        stage_q   <= 2'd0;
                        iter_q    <= 5'd0;
                        ready_q   <= 1'b0;
                        load_en_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state_q      <= S_RUN;
                    load_en_q    <= 1'b0;
                    stage_en_q   <= 1'b1;
                    stage_q      <= 2'd0;
                    iter_q       <= 5'd0;
                    commit_q     <= FIRST_COMMIT;
                    last_round_q <= FIRST_LAST;
                end
                S_RUN: begin
                    // commit_q is high exactly when stage_q is the last stage, and
                    // last_round_q exactly when iter_q is the last round.
                    if (commit_q) begin
                        stage_q <= 2'd0;
                        if (last_round_q) begin
                            state_q      <= S_DONE;
                            stage_en_q   <= 1'b0;
                            commit_q     <= 1'b0;
                            last_round_q <= 1'b0;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                        end else begin
                            iter_q       <= iter_q + 5'd1;
                            commit_q     <= FIRST_COMMIT;
                            last_round_q <= ((iter_q + 5'd1) == LAST_ITER);
                        end
                    end else begin
                        stage_q  <= stage_q + 2'd1;
                        commit_q <= ((stage_q + 2'd1) == LAST_STAGE);
                    end
                end
                S_DONE: begin
                    // start is ignored here; only ack leaves DONE.
                    if (ctrl.ack) begin
                        state_q <= S_IDLE;
                        iter_q  <= 5'd0;
                        stage_q <= 2'd0;
                        done_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    stage_q      <= 2'd0;
                    iter_q       <= 5'd0;
                    ready_q      <= 1'b1;
                    load_en_q    <= 1'b0;
                    stage_en_q   <= 1'b0;
                    commit_q     <= 1'b0;
                    last_round_q <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                end
            endcase
        end
    end

    assign ctrl.ready      = ready_q;
    assign ctrl.load_en    = load_en_q;
    assign ctrl.stage_en   = stage_en_q;
    assign ctrl.stage      = stage_q;
    assign ctrl.iteration  = iter_q;
    assign ctrl.commit     = commit_q;
    assign ctrl.last_round = last_round_q;
    assign ctrl.busy       = busy_q;
    assign ctrl.done       = done_q;

endmodule
